// File: rtl/alsu_param_estado.sv
// Registered, parametrised ALSU with start/ready/valid handshake and a persistent status register.
// Optional macro ALSU_BARRIL_EN: single-cycle barrel shifts/rotates instead of one bit per cycle.
module alsu_param_estado #(
   parameter int ANCHO        = 16,
   parameter int ANCHO_CUENTA = 4
) (
   input  logic                    Reloj,
   input  logic                    Reset,
   input  logic                    Inicio,
   output logic                    Listo,
   output logic                    Valido,
   input  logic [ANCHO-1:0]        EntradaA,
   input  logic [ANCHO-1:0]        EntradaB,
   input  logic [3:0]              Selector,
   input  logic [ANCHO_CUENTA-1:0] Cuenta,
   output logic [ANCHO-1:0]        Salida,
   output logic                    Acarreo,
   output logic                    Desbordamiento,
   output logic                    Cero,
   output logic                    Negativo
);

   localparam int MSB = ANCHO - 1;
   localparam logic [ANCHO:0]        UNO_EXT  = 1;
   localparam logic [ANCHO_CUENTA-1:0] CNT_UNO = 1;

   localparam logic [3:0] OP_NOT  = 4'b0000, OP_AND  = 4'b0001, OP_XOR = 4'b0010, OP_OR  = 4'b0011;
   localparam logic [3:0] OP_DEC  = 4'b0100, OP_ADD  = 4'b0101, OP_SUB = 4'b0110, OP_INC = 4'b0111;
   localparam logic [3:0] OP_MOV  = 4'b1000, OP_RLC  = 4'b1001, OP_TEST = 4'b1010, OP_RRC = 4'b1011;
   localparam logic [3:0] OP_SL   = 4'b1100, OP_RL   = 4'b1101, OP_SR  = 4'b1110, OP_RR  = 4'b1111;

`ifdef ALSU_BARRIL_EN
   typedef enum logic [1:0] {OCIOSO, CALCULA} estado_e;
`else
   typedef enum logic [1:0] {OCIOSO, CALCULA, DESPLAZA} estado_e;
`endif

   function automatic logic es_desplaza(input logic [3:0] sel);
      return sel[3] & (sel[2] | sel[0]);
   endfunction

`ifdef ALSU_BARRIL_EN
   // Rotates over ANCHO+1 bits; each count bit contributes a constant amount modulo the width.
   function automatic logic [ANCHO:0] gira_ext(input logic [ANCHO:0] v,
                                               input logic [ANCHO_CUENTA-1:0] n, input logic izq);
      logic [ANCHO:0] r;
      r = v;
      for (int k = 0; k < ANCHO_CUENTA; k++) begin
         int s;
         s = (1 << k) % (ANCHO + 1);
         if (n[k] && s != 0)
            r = izq ? ((r << s) | (r >> (ANCHO + 1 - s))) : ((r >> s) | (r << (ANCHO + 1 - s)));
      end
      return r;
   endfunction

   function automatic logic [ANCHO-1:0] gira(input logic [ANCHO-1:0] v,
                                             input logic [ANCHO_CUENTA-1:0] n, input logic izq);
      logic [ANCHO-1:0] r;
      r = v;
      for (int k = 0; k < ANCHO_CUENTA; k++) begin
         int s;
         s = (1 << k) % ANCHO;
         if (n[k] && s != 0)
            r = izq ? ((r << s) | (r >> (ANCHO - s))) : ((r >> s) | (r << (ANCHO - s)));
      end
      return r;
   endfunction

   // Returns {carry, value}; n must be non-zero.
   function automatic logic [ANCHO:0] barril(input logic [3:0] sel, input logic [ANCHO-1:0] v,
                                             input logic c, input logic [ANCHO_CUENTA-1:0] n);
      logic [ANCHO:0]   e;
      logic [ANCHO-1:0] g;
      e = '0;
      g = '0;
      case (sel)
         OP_RLC:  e = gira_ext({c, v}, n, 1'b1);
         OP_RRC:  e = gira_ext({c, v}, n, 1'b0);
         OP_SL:   e = {1'b0, v} << n;
         OP_SR:   begin
            e = {v, 1'b0} >> n;
            e = {e[0], e[ANCHO:1]};
         end
         OP_RL:   begin
            g = gira(v, n, 1'b1);
            e = {g[0], g};
         end
         default: begin
            g = gira(v, n, 1'b0);
            e = {g[MSB], g};
         end
      endcase
      return e;
   endfunction
`else
   // One serial step; returns {carry, value}.
   function automatic logic [ANCHO:0] paso(input logic [3:0] sel, input logic [ANCHO-1:0] v,
                                           input logic c);
      logic [ANCHO:0] r;
      case (sel)
         OP_RLC:  r = {v, c};
         OP_RRC:  r = {v[0], c, v[MSB:1]};
         OP_SL:   r = {v, 1'b0};
         OP_RL:   r = {v, v[MSB]};
         OP_SR:   r = {v[0], 1'b0, v[MSB:1]};
         default: r = {v[0], v[0], v[MSB:1]};
      endcase
      return r;
   endfunction
`endif

   estado_e                 state_q, state_d;
   logic [ANCHO-1:0]        a_q, a_d, b_q, b_d, trab_q, trab_d, salida_q, salida_d;
   logic [3:0]              sel_q, sel_d;
   logic [ANCHO_CUENTA-1:0] cnt_q, cnt_d;
   logic                    trab_c_q, trab_c_d, valido_q, valido_d;
   logic                    acarreo_q, acarreo_d, desb_q, desb_d, cero_q, cero_d, neg_q, neg_d;
   logic [ANCHO:0]          suma, desp;
   logic [ANCHO-1:0]        res;
   logic                    desb_ar;

   // State register
   always_ff @(posedge Reloj or posedge Reset) begin
      if (Reset) state_q <= OCIOSO;
      else       state_q <= state_d;
   end

   // Next-state logic; Listo is high exactly in OCIOSO, so Inicio there is an acceptance.
   always_comb begin
      state_d = state_q;
      case (state_q)
`ifdef ALSU_BARRIL_EN
         OCIOSO:   if (Inicio) state_d = CALCULA;
`else
         OCIOSO:   if (Inicio) state_d = (es_desplaza(Selector) && Cuenta != '0) ? DESPLAZA : CALCULA;
         DESPLAZA: if (cnt_q == CNT_UNO) state_d = OCIOSO;
`endif
         CALCULA:  state_d = OCIOSO;
         default:  state_d = OCIOSO;
      endcase
   end

   // Outputs
   always_comb begin
      Listo = (state_q == OCIOSO);
   end

   assign Valido         = valido_q;
   assign Salida         = salida_q;
   assign Acarreo        = acarreo_q;
   assign Desbordamiento = desb_q;
   assign Cero           = cero_q;
   assign Negativo       = neg_q;

   // Arithmetic unit, ANCHO+1 bits so bit ANCHO is carry (or borrow for SUB/DEC/TEST).
   always_comb begin
      suma    = '0;
      desb_ar = 1'b0;
      case (sel_q)
         OP_DEC: begin
            suma    = {1'b0, a_q} - UNO_EXT;
            desb_ar = (a_q == {1'b1, {MSB{1'b0}}});
         end
         OP_INC: begin
            suma    = {1'b0, a_q} + UNO_EXT;
            desb_ar = (a_q == {1'b0, {MSB{1'b1}}});
         end
         OP_ADD: begin
            suma    = {1'b0, a_q} + {1'b0, b_q};
            desb_ar = (a_q[MSB] == b_q[MSB]) && (suma[MSB] != a_q[MSB]);
         end
         OP_SUB, OP_TEST: begin
            suma    = {1'b0, a_q} - {1'b0, b_q};
            desb_ar = (a_q[MSB] != b_q[MSB]) && (suma[MSB] != a_q[MSB]);
         end
         default: ;
      endcase
   end

   // Datapath next-state.
   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      trab_d    = trab_q;
      trab_c_d  = trab_c_q;
      salida_d  = salida_q;
      acarreo_d = acarreo_q;
      desb_d    = desb_q;
      cero_d    = cero_q;
      neg_d     = neg_q;
      valido_d  = 1'b0;
      desp      = '0;
      res       = '0;
      case (state_q)
         OCIOSO: if (Inicio) begin
            a_d      = EntradaA;
            b_d      = EntradaB;
            sel_d    = Selector;
            cnt_d    = Cuenta;
            trab_d   = EntradaA;
            trab_c_d = acarreo_q;
         end
         CALCULA: begin
            valido_d = 1'b1;
            if (es_desplaza(sel_q)) begin
`ifdef ALSU_BARRIL_EN
               desp = (cnt_q != '0) ? barril(sel_q, a_q, acarreo_q, cnt_q) : {acarreo_q, a_q};
`else
               desp = {acarreo_q, a_q};
`endif
               salida_d  = desp[MSB:0];
               acarreo_d = desp[ANCHO];
               cero_d    = ~|desp[MSB:0];
               neg_d     = desp[MSB];
            end else if (sel_q[3:2] == 2'b01 || sel_q == OP_TEST) begin
               if (sel_q != OP_TEST) salida_d = suma[MSB:0];
               acarreo_d = suma[ANCHO];
               desb_d    = desb_ar;
               cero_d    = ~|suma[MSB:0];
               neg_d     = suma[MSB];
            end else begin
               case (sel_q)
                  OP_NOT:  res = ~a_q;
                  OP_AND:  res = a_q & b_q;
                  OP_XOR:  res = a_q ^ b_q;
                  OP_OR:   res = a_q | b_q;
                  default: res = a_q;
               endcase
               salida_d = res;
               cero_d   = ~|res;
               neg_d    = res[MSB];
            end
         end
`ifndef ALSU_BARRIL_EN
         DESPLAZA: begin
            desp     = paso(sel_q, trab_q, trab_c_q);
            trab_d   = desp[MSB:0];
            trab_c_d = desp[ANCHO];
            cnt_d    = cnt_q - CNT_UNO;
            // Only the final step is committed; intermediate values stay internal.
            if (cnt_q == CNT_UNO) begin
               salida_d  = desp[MSB:0];
               acarreo_d = desp[ANCHO];
               cero_d    = ~|desp[MSB:0];
               neg_d     = desp[MSB];
               valido_d  = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so all flops sample the same pre-edge values.
   always_ff @(posedge Reloj or posedge Reset) begin
      if (Reset) begin
         a_q       <= '0;
         b_q       <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
         trab_q    <= '0;
         trab_c_q  <= 1'b0;
         salida_q  <= '0;
         acarreo_q <= 1'b0;
         desb_q    <= 1'b0;
         cero_q    <= 1'b0;
         neg_q     <= 1'b0;
         valido_q  <= 1'b0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         trab_q    <= trab_d;
         trab_c_q  <= trab_c_d;
         salida_q  <= salida_d;
         acarreo_q <= acarreo_d;
         desb_q    <= desb_d;
         cero_q    <= cero_d;
         neg_q     <= neg_d;
         valido_q  <= valido_d;
      end
   end

endmodule

// File: tb/tb_alsu_param_estado.sv
// Directed self-checking bench for alsu_param_estado (default serial build, ANCHO=16).
// Flags are compared as {Acarreo, Desbordamiento, Cero, Negativo}.
module tb_alsu_param_estado;

   logic        Reloj = 1'b0;
   logic        Reset = 1'b1;
   logic        Inicio = 1'b0;
   logic        Listo, Valido;
   logic [15:0] EntradaA = '0, EntradaB = '0;
   logic [3:0]  Selector = '0;
   logic [3:0]  Cuenta = '0;
   logic [15:0] Salida;
   logic        Acarreo, Desbordamiento, Cero, Negativo;

   int n_checks = 0;
   int n_errors = 0;

   alsu_param_estado #(.ANCHO(16), .ANCHO_CUENTA(4)) dut (
      .Reloj(Reloj), .Reset(Reset), .Inicio(Inicio), .Listo(Listo), .Valido(Valido),
      .EntradaA(EntradaA), .EntradaB(EntradaB), .Selector(Selector), .Cuenta(Cuenta),
      .Salida(Salida), .Acarreo(Acarreo), .Desbordamiento(Desbordamiento),
      .Cero(Cero), .Negativo(Negativo)
   );

   always #5 Reloj = ~Reloj;

   function automatic logic [31:0] flags();
      return 32'({Acarreo, Desbordamiento, Cero, Negativo});
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one request at the next edge, then scrambles the inputs to prove they were latched.
   task automatic issue(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] c);
      check("listo_before_issue", 32'(Listo), 32'd1);
      Selector = sel;
      EntradaA = a;
      EntradaB = b;
      Cuenta   = c;
      Inicio   = 1'b1;
      @(posedge Reloj);
      #1;
      Inicio   = 1'b0;
      Selector = ~sel;
      EntradaA = ~a;
      EntradaB = ~b;
      Cuenta   = ~c;
   endtask

   // lat = number of edges after the acceptance edge until Valido is seen.
   task automatic expect_result(input string tag, input int lat, input logic [15:0] sal,
                                input logic [3:0] flg);
      int n;
      n = 0;
      do begin
         @(posedge Reloj);
         #1;
         n++;
      end while (!Valido && n < 40);
      check({tag, "_lat"}, 32'(n), 32'(lat));
      check({tag, "_sal"}, 32'(Salida), 32'(sal));
      check({tag, "_flg"}, flags(), 32'(flg));
      check({tag, "_listo"}, 32'(Listo), 32'd1);
   endtask

   initial begin
      int vcount;
      repeat (2) @(posedge Reloj);
      #1;
      check("rst_sal", 32'(Salida), 32'h0);
      check("rst_flg", flags(), 32'h0);
      check("rst_valido", 32'(Valido), 32'd0);
      check("rst_listo", 32'(Listo), 32'd1);
      Reset = 1'b0;
      @(posedge Reloj);
      #1;

      issue(4'b0101, 16'h7FFF, 16'h0001, 4'd0);   // ADD signed overflow
      expect_result("add_ovf", 1, 16'h8000, 4'b0101);
      @(posedge Reloj);
      #1;
      check("add_valido_width", 32'(Valido), 32'd0);

      issue(4'b0110, 16'h0003, 16'h0005, 4'd0);   // SUB with borrow
      expect_result("sub_borrow", 1, 16'hFFFE, 4'b1001);
      issue(4'b1010, 16'h1234, 16'h1234, 4'd0);   // TEST keeps Salida
      expect_result("test_eq", 1, 16'hFFFE, 4'b0010);
      issue(4'b0101, 16'hFFFF, 16'h0001, 4'd0);   // ADD carry out, zero
      expect_result("add_carry", 1, 16'h0000, 4'b1010);
      issue(4'b0000, 16'h00FF, 16'h0000, 4'd0);   // NOT: carry/overflow hold
      expect_result("not", 1, 16'hFF00, 4'b1001);
      issue(4'b1001, 16'h0000, 16'h0000, 4'd1);   // RLC pulls stored carry in
      expect_result("rlc1", 1, 16'h0001, 4'b0000);
      issue(4'b0010, 16'h5A5A, 16'h5A5A, 4'd0);   // back-to-back XOR on Valido cycle
      expect_result("xor_b2b", 1, 16'h0000, 4'b0010);
      issue(4'b0111, 16'h7FFF, 16'h0000, 4'd0);   // INC overflow
      expect_result("inc_ovf", 1, 16'h8000, 4'b0101);
      issue(4'b0011, 16'h0000, 16'h0000, 4'd0);   // OR: overflow holds
      expect_result("or_hold", 1, 16'h0000, 4'b0110);
      issue(4'b0100, 16'h8000, 16'h0000, 4'd0);   // DEC overflow
      expect_result("dec_ovf", 1, 16'h7FFF, 4'b0100);
      issue(4'b0100, 16'h0000, 16'h0000, 4'd0);   // DEC borrow
      expect_result("dec_borrow", 1, 16'hFFFF, 4'b1001);
      issue(4'b0110, 16'h8000, 16'h0001, 4'd0);   // SUB overflow
      expect_result("sub_ovf", 1, 16'h7FFF, 4'b0100);
      issue(4'b1000, 16'h0000, 16'hFFFF, 4'd0);   // MOV
      expect_result("mov", 1, 16'h0000, 4'b0110);
      issue(4'b0111, 16'hFFFF, 16'h0000, 4'd0);   // INC wrap
      expect_result("inc_wrap", 1, 16'h0000, 4'b1010);

      // SR by 4 with an ignored request in the middle
      issue(4'b1110, 16'h8001, 16'h0000, 4'd4);
      check("sr_listo_c1", 32'(Listo), 32'd0);
      @(posedge Reloj);
      #1;
      check("sr_listo_c2", 32'(Listo), 32'd0);
      check("sr_hidden_c2", 32'(Salida), 32'h0000);
      Selector = 4'b0101;
      EntradaA = 16'h0001;
      EntradaB = 16'h0001;
      Inicio   = 1'b1;
      @(posedge Reloj);
      #1;
      Inicio = 1'b0;
      check("sr_listo_c3", 32'(Listo), 32'd0);
      @(posedge Reloj);
      #1;
      check("sr_listo_c4", 32'(Listo), 32'd0);
      check("sr_valido_c4", 32'(Valido), 32'd0);
      @(posedge Reloj);
      #1;
      check("sr4_valido", 32'(Valido), 32'd1);
      check("sr4_sal", 32'(Salida), 32'h0800);
      check("sr4_flg", flags(), 32'h0);
      vcount = 0;
      repeat (4) begin
         @(posedge Reloj);
         #1;
         if (Valido) vcount++;
      end
      check("sr4_ignored_req", 32'(vcount), 32'd0);
      check("sr4_sal_hold", 32'(Salida), 32'h0800);

      issue(4'b1100, 16'h8001, 16'h0000, 4'd1);   // SL carry out
      expect_result("sl1", 1, 16'h0002, 4'b1000);
      issue(4'b1101, 16'h8001, 16'h0000, 4'd4);   // RL by 4
      expect_result("rl4", 4, 16'h0018, 4'b0000);
      issue(4'b1111, 16'h0001, 16'h0000, 4'd1);   // RR by 1
      expect_result("rr1", 1, 16'h8000, 4'b1001);
      issue(4'b1100, 16'h1234, 16'h0000, 4'd0);   // count 0: pass A, carry holds
      expect_result("sl0", 1, 16'h1234, 4'b1000);
      issue(4'b1011, 16'h0001, 16'h0000, 4'd2);   // RRC by 2 through carry=1
      expect_result("rrc2", 2, 16'hC000, 4'b0001);
      issue(4'b1110, 16'hFFFF, 16'h0000, 4'd15);  // max count
      expect_result("sr15", 15, 16'h0001, 4'b1000);

      // Reset during 3rd shift cycle of RR by 8
      issue(4'b1111, 16'h1234, 16'h0000, 4'd8);
      @(posedge Reloj);
      #1;
      @(posedge Reloj);
      #1;
      check("rr8_hidden", 32'(Salida), 32'h0001);
      Reset = 1'b1;
      #1;
      check("abort_sal", 32'(Salida), 32'h0);
      check("abort_flg", flags(), 32'h0);
      check("abort_listo", 32'(Listo), 32'd1);
      check("abort_valido", 32'(Valido), 32'd0);
      @(posedge Reloj);
      #1;
      Reset  = 1'b0;
      vcount = 0;
      repeat (12) begin
         @(posedge Reloj);
         #1;
         if (Valido) vcount++;
      end
      check("abort_no_valido", 32'(vcount), 32'd0);

      issue(4'b0101, 16'h0001, 16'h0002, 4'd0);
      expect_result("add_after_rst", 1, 16'h0003, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
